// File: rtl/sync_pkg.sv
// sync_pkg: shared definitions for the sync_filt input conditioner.
//   filt_cnt_w()  - width of the per-channel stability counter
//   filt_state_e  - STABLE/PENDING view of a channel's filter, used only
//                   for assertions and waveform annotation
package sync_pkg;

  typedef enum logic {
    STABLE  = 1'b0,  // synchronized level agrees with out, counter idle
    PENDING = 1'b1   // synchronized level disagrees, counting toward acceptance
  } filt_state_e;

  // Counter must hold 0 .. filt_cycles-1; never narrower than one bit.
  function automatic int filt_cnt_w(input int filt_cycles);
    int w;
    w = $clog2(filt_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_filt_chan.sv
// sync_filt_chan: one channel of the input conditioner.
//   STAGES-deep synchronizer chain followed by a stability filter that
//   accepts a new level only after it persists FILT_CYCLES cycles.
// Ports:
//   clk     in   sole clock
//   rst     in   synchronous active-high reset
//   in_bit  in   asynchronous input
//   out_bit out  filtered level (registered)
//   rise    out  one-cycle pulse on out_bit 0->1 (registered)
//   fall    out  one-cycle pulse on out_bit 1->0 (registered)
module sync_filt_chan
  import sync_pkg::*;
#(
  parameter int   STAGES      = 2,
  parameter int   FILT_CYCLES = 4,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic in_bit,
  output logic out_bit,
  output logic rise,
  output logic fall
);

  localparam int              CW      = filt_cnt_w(FILT_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(FILT_CYCLES - 1);

  // Metastability chain: keep the flops adjacent and untouched by
  // retiming or replication.
  (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *)
  logic [STAGES-1:0] sync_reg;

  logic [CW-1:0] cnt_reg;
  logic          sync_lvl;

  assign sync_lvl = sync_reg[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= {STAGES{RST_VAL}};
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], in_bit};
    end
  end

  // Stability filter. cnt_reg counts consecutive disagreeing cycles; the
  // cycle that would reach FILT_CYCLES is the acceptance cycle, so the
  // counter itself never needs to hold FILT_CYCLES.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_bit <= RST_VAL;
      cnt_reg <= '0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync_lvl == out_bit) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_MAX) begin
        out_bit <= sync_lvl;
        cnt_reg <= '0;
        rise    <= sync_lvl;
        fall    <= ~sync_lvl;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  // Filter view for waveforms and assertions.
  filt_state_e state;
  assign state = (cnt_reg == '0 && sync_lvl == out_bit) ? STABLE : PENDING;

  no_dual_pulse: assert property (@(posedge clk) disable iff (rst) !(rise && fall));

  cnt_in_range: assert property (@(posedge clk) disable iff (rst)
    (state == PENDING) |-> (cnt_reg <= CNT_MAX));

  stable_idle: assert property (@(posedge clk) disable iff (rst)
    (state == STABLE) |=> (!rise && !fall));

endmodule

// File: rtl/sync_filt.sv
// sync_filt: WIDTH independent channels of synchronizer + stability filter.
// Ports:
//   clk       in   sole clock, all state on posedge
//   rst       in   synchronous active-high reset
//   in_data   in   WIDTH asynchronous inputs
//   out_data  out  WIDTH filtered synchronized levels (registered)
//   rise      out  WIDTH one-cycle pulses on out_data 0->1 (registered)
//   fall      out  WIDTH one-cycle pulses on out_data 1->0 (registered)
module sync_filt
  import sync_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               STAGES      = 2,
  parameter int               FILT_CYCLES = 4,
  parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // Channels share nothing but clock and reset.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      sync_filt_chan #(
        .STAGES      (STAGES),
        .FILT_CYCLES (FILT_CYCLES),
        .RST_VAL     (RST_VAL[gi])
      ) u_chan (
        .clk     (clk),
        .rst     (rst),
        .in_bit  (in_data[gi]),
        .out_bit (out_data[gi]),
        .rise    (rise[gi]),
        .fall    (fall[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sync_filt.sv
// tb_sync_filt: self-checking bench for sync_filt across several parameter
// sets. Each configuration has a behavioural reference model; directed
// phases additionally check hand-derived cycle timings.
module tb_sync_filt;

  localparam int NCFG = 13;

  // Configuration table: 0/1 are the default geometry (RST_VAL A5 / 00),
  // 2..10 sweep STAGES x FILT_CYCLES at WIDTH 16, 11/12 are WIDTH 1.
  function automatic int cfg_w(input int i);
    if (i < 2) return 8;
    else if (i < 11) return 16;
    else return 1;
  endfunction

  function automatic int cfg_s(input int i);
    if (i < 2) return 2;
    else if (i < 11) return 2 + (i - 2) / 3;
    else if (i == 11) return 3;
    else return 4;
  endfunction

  function automatic int cfg_f(input int i);
    int r;
    if (i < 2) return 4;
    else if (i < 11) begin
      r = (i - 2) % 3;
      return (r == 0) ? 1 : ((r == 1) ? 2 : 5);
    end
    else if (i == 11) return 2;
    else return 5;
  endfunction

  function automatic logic [15:0] cfg_rst(input int i);
    if (i == 0) return 16'h00A5;
    else if (i == 1) return 16'h0000;
    else if (i < 11) return 16'h0F3C;
    else if (i == 11) return 16'h0000;
    else return 16'h0001;
  endfunction

  function automatic logic [15:0] wmask(input int i);
    if (cfg_w(i) == 16) return 16'hFFFF;
    else return (16'd1 << cfg_w(i)) - 16'd1;
  endfunction

  logic        clk;
  logic        rst;
  logic [15:0] stim     [NCFG];
  logic [15:0] obs_out  [NCFG];
  logic [15:0] obs_rise [NCFG];
  logic [15:0] obs_fall [NCFG];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
      localparam int             W  = cfg_w(gi);
      localparam int             S  = cfg_s(gi);
      localparam int             F  = cfg_f(gi);
      localparam logic [W-1:0]   RV = W'(cfg_rst(gi));

      logic [W-1:0] in_data, out_data, rise, fall;

      assign in_data       = stim[gi][W-1:0];
      assign obs_out[gi]   = 16'(out_data);
      assign obs_rise[gi]  = 16'(rise);
      assign obs_fall[gi]  = 16'(fall);

      sync_filt #(
        .WIDTH       (W),
        .STAGES      (S),
        .FILT_CYCLES (F),
        .RST_VAL     (RV)
      ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .out_data (out_data),
        .rise     (rise),
        .fall     (fall)
      );

      // Reference model: the sync level seen at an edge is the input
      // sampled S edges earlier (a queue of past samples); a channel
      // accepts a new level once it has disagreed with out for F edges
      // in a row.
      logic [W-1:0] m_out, m_rise, m_fall;
      logic [W-1:0] hist_q[$];
      int           run[W];
      bit           m_valid = 1'b0;

      always @(posedge clk) begin
        logic [W-1:0] sync_w;
        if (rst) begin
          hist_q.delete();
          for (int k = 0; k < S; k++) hist_q.push_back(RV);
          m_out   = RV;
          m_rise  = '0;
          m_fall  = '0;
          foreach (run[c]) run[c] = 0;
          m_valid = 1'b1;
        end else if (m_valid) begin
          sync_w = hist_q.pop_front();
          hist_q.push_back(in_data);
          m_rise = '0;
          m_fall = '0;
          for (int c = 0; c < W; c++) begin
            if (sync_w[c] == m_out[c]) begin
              run[c] = 0;
            end else begin
              run[c] = run[c] + 1;
              if (run[c] == F) begin
                m_out[c] = sync_w[c];
                if (sync_w[c]) m_rise[c] = 1'b1;
                else           m_fall[c] = 1'b1;
                run[c] = 0;
              end
            end
          end
        end
      end

      always @(negedge clk) begin
        if (m_valid) begin
          check($sformatf("cfg%0d_out", gi),  16'(out_data), 16'(m_out));
          check($sformatf("cfg%0d_rise", gi), 16'(rise),     16'(m_rise));
          check($sformatf("cfg%0d_fall", gi), 16'(fall),     16'(m_fall));
        end
      end
    end
  endgenerate

  logic [15:0] sw_mask [NCFG];

  initial begin
    int          lat;
    logic [15:0] rv, e_out, e_rise, e_fall;

    // Reset check: cfg0 has RST_VAL A5 and its input held at A5.
    rst = 1'b1;
    for (int i = 0; i < NCFG; i++) stim[i] = cfg_rst(i) & wmask(i);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_out",   obs_out[0],  16'h00A5);
      check("rst_pulse", obs_rise[0] | obs_fall[0], 16'h0000);
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("post_rst_out",   obs_out[0],  16'h00A5);
      check("post_rst_pulse", obs_rise[0] | obs_fall[0], 16'h0000);
    end
    $display("reset check on cfg0 complete");

    // Step latency on cfg1 channel 0: accepted after 6 edges.
    for (int k = 1; k <= 8; k++) begin
      stim[1][0] = 1'b1;
      @(negedge clk);
      check($sformatf("step_out_k%0d", k),  16'(obs_out[1][0]),  16'(k >= 6));
      check($sformatf("step_rise_k%0d", k), 16'(obs_rise[1][0]), 16'(k == 6));
      check($sformatf("step_fall_k%0d", k), obs_fall[1], 16'h0000);
    end
    $display("step latency on cfg1 ch0 complete");

    // Glitch: 3 cycles high on channel 3 never reaches the output.
    for (int k = 1; k <= 12; k++) begin
      stim[1][3] = (k <= 3);
      @(negedge clk);
      check($sformatf("glitch_out_k%0d", k), 16'(obs_out[1][3]), 16'h0000);
      check($sformatf("glitch_pls_k%0d", k), 16'(obs_rise[1][3] | obs_fall[1][3]), 16'h0000);
    end
    $display("glitch rejection on cfg1 ch3 complete");

    // 4-cycle pulse: rise at edge 6, fall 4 edges after the sync level drops.
    for (int k = 1; k <= 14; k++) begin
      stim[1][3] = (k <= 4);
      @(negedge clk);
      check($sformatf("pulse_out_k%0d", k),  16'(obs_out[1][3]),  16'(k >= 6 && k < 10));
      check($sformatf("pulse_rise_k%0d", k), 16'(obs_rise[1][3]), 16'(k == 6));
      check($sformatf("pulse_fall_k%0d", k), 16'(obs_fall[1][3]), 16'(k == 10));
    end
    $display("minimum pulse on cfg1 ch3 complete");

    // Counter restart: high 3, low 1, high held on channel 1.
    for (int k = 1; k <= 14; k++) begin
      stim[1][1] = (k <= 3) || (k >= 5);
      @(negedge clk);
      check($sformatf("restart_out_k%0d", k),  16'(obs_out[1][1]),  16'(k >= 10));
      check($sformatf("restart_rise_k%0d", k), 16'(obs_rise[1][1]), 16'(k == 10));
    end
    $display("counter restart on cfg1 ch1 complete");

    // Mid-operation reset while channels 2..7 are two cycles into counting.
    for (int k = 1; k <= 16; k++) begin
      rst = (k == 5);
      stim[1] = 16'h00FF;
      @(negedge clk);
      if (k >= 5) begin
        check($sformatf("midrst_out_k%0d", k),  obs_out[1],  (k >= 11) ? 16'h00FF : 16'h0000);
        check($sformatf("midrst_rise_k%0d", k), obs_rise[1], (k == 11) ? 16'h00FF : 16'h0000);
        check($sformatf("midrst_fall_k%0d", k), obs_fall[1], 16'h0000);
      end
    end
    rst = 1'b0;
    $display("mid-operation reset complete");

    // Sweep: reset to RST_VAL, then a random subset of channels steps.
    rst = 1'b1;
    for (int i = 0; i < NCFG; i++) stim[i] = cfg_rst(i) & wmask(i);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NCFG; i++) begin
      sw_mask[i] = 16'($urandom) & wmask(i);
      if (sw_mask[i] == 16'h0000) sw_mask[i] = 16'h0001;
    end
    for (int k = 1; k <= 12; k++) begin
      for (int i = 0; i < NCFG; i++) stim[i] = (cfg_rst(i) & wmask(i)) ^ sw_mask[i];
      @(negedge clk);
      for (int i = 0; i < NCFG; i++) begin
        lat    = cfg_s(i) + cfg_f(i);
        rv     = cfg_rst(i) & wmask(i);
        e_out  = (k >= lat) ? (rv ^ sw_mask[i]) : rv;
        e_rise = (k == lat) ? (sw_mask[i] & ~rv) : 16'h0000;
        e_fall = (k == lat) ? (sw_mask[i] & rv)  : 16'h0000;
        check($sformatf("sweep%0d_out_k%0d", i, k),  obs_out[i],  e_out);
        check($sformatf("sweep%0d_rise_k%0d", i, k), obs_rise[i], e_rise);
        check($sformatf("sweep%0d_fall_k%0d", i, k), obs_fall[i], e_fall);
      end
    end
    $display("parameter sweep step latency complete");

    // Random toggling with occasional resets; models check every cycle.
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NCFG; i++)
        stim[i] = stim[i] ^ (16'($urandom) & 16'($urandom) & 16'($urandom) & wmask(i));
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("random stimulus phase complete");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_filt.md
# sync_filt

Parametrised multi-channel input conditioner; successor to the fixed two-flop synchronizer. Each of WIDTH independent asynchronous inputs passes through a STAGES-deep synchronizer chain and a per-channel stability filter. The filter turns the synchronized level into a debounced level output plus one-cycle rise and fall pulses. It sits at the boundary of the clk domain, in front of any control logic that consumes off-chip or cross-domain level signals.

## Interface
- WIDTH, 8: number of independent channels (≥1)
- STAGES, 2: synchronizer flops per channel (≥2)
- FILT_CYCLES, 4: consecutive cycles a new synchronized level must persist before it is accepted (≥1)
- RST_VAL, '0 (WIDTH bits): per-channel reset level for the synchronizer chain and out_data
- clk  in  1  sole clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- in_data  in  WIDTH  asynchronous inputs; no timing relationship to clk
- out_data  out  WIDTH  filtered, synchronized level per channel (registered)
- rise  out  WIDTH  one-cycle pulse, registered, when out_data[i] goes 0→1
- fall  out  WIDTH  one-cycle pulse, registered, when out_data[i] goes 1→0

## Operation
- Channels are fully independent; no cross-channel state.
- Sync chain per channel: s[0] <= in_data[i], s[k] <= s[k-1]; sync level = s[STAGES-1].
- Filter per channel holds cnt, width $clog2(FILT_CYCLES) (minimum 1 bit).
  - sync == out_data[i]: cnt <= 0 and no pulse.
  - sync != out_data[i] and cnt < FILT_CYCLES-1: cnt <= cnt+1.
  - sync != out_data[i] and cnt == FILT_CYCLES-1: out_data[i] <= sync and cnt <= 0. Assert rise[i] if sync=1, otherwise fall[i], for exactly that cycle.
- Any cycle of agreement restarts the count. A glitch on the synchronized level shorter than FILT_CYCLES cycles never reaches out_data.
- rise and fall default to 0 every cycle. They are never both high, and never high in consecutive cycles for the same channel when FILT_CYCLES ≥ 2.
- The filter state is two-valued per channel: STABLE (cnt=0, agree) and PENDING (disagree, counting). It returns to STABLE on acceptance or on agreement.
- Reset, including mid-operation:
  - All sync flops and out_data load RST_VAL.
  - cnt loads 0.
  - rise and fall load 0.
  - In-flight pending changes are discarded.
- After reset, if in_data[i] ≠ RST_VAL[i], one legitimate edge pulse follows after the normal latency. There is no pulse if the input equals RST_VAL.

## Timing
- Latency, clean step on in_data[i] to out_data[i]/pulse: STAGES + FILT_CYCLES posedges. Defaults: 6.
- The sync level changes STAGES edges after the input is sampled. Acceptance happens FILT_CYCLES edges later.
- Minimum accepted pulse width at the sync level: FILT_CYCLES cycles.
- Minimum pulse width on in_data: FILT_CYCLES cycles plus metastability uncertainty of ±1 cycle.
- Throughput: a channel can toggle out_data at most once per FILT_CYCLES cycles.
- No combinational path from in_data to any output. All outputs come straight from flops.

## Structure
- Package sync_pkg holds:
  - function filt_cnt_w(FILT_CYCLES), returning max(1, $clog2(FILT_CYCLES));
  - the STABLE/PENDING enum, used only for assertions and waveform annotation.
- Sub-module sync_filt_chan: one channel (chain, counter, out, rise, fall), parameters STAGES, FILT_CYCLES and a 1-bit RST_VAL.
- sync_filt generates WIDTH instances of sync_filt_chan.
- Synthesis attributes for the sync chain (ASYNC_REG / don't-touch) are applied inside sync_filt_chan.

## Test plan
- Reset check: defaults, RST_VAL=8'hA5, rst held 3 cycles with in_data=8'hA5 → out_data=8'hA5, rise=fall=0 during and after reset; no pulses for 20 cycles.
- Step latency: defaults, RST_VAL=0, in_data[0] 0→1 held → out_data[0]=1 and rise[0]=1 exactly 6 edges later, for 1 cycle; fall=0 throughout.
- Glitch rejection: FILT_CYCLES=4, in_data[3] high for 3 cycles then low → out_data[3] stays 0 and no pulses. A 4-cycle high pulse → rise[3] then, 4 cycles after the sync level falls, fall[3].
- Counter restart: in_data[1] high 3 cycles, low 1 cycle, high held → acceptance occurs 4 cycles after the final rising sync level, not earlier.
- Parameter sweep: STAGES∈{2,3,4} × FILT_CYCLES∈{1,2,5}, WIDTH=1 and 16, random per-channel steps → latency = STAGES+FILT_CYCLES per channel; channels independent.
- Mid-operation reset: in_data=8'hFF, assert rst one cycle while cnt=2 → out_data=RST_VAL next cycle, cnt cleared. rise pulses reappear exactly STAGES+FILT_CYCLES edges after rst deasserts.
